clock_gate_ctrl: RTL
====================

Name: clock_gate_ctrl

Overview:
- Idle-timeout controller that drives the enable inputs of NUM_DOMAINS downstream clock-gating cells, one cell per NPU sub-block (PE array, buffers, DMA, ...).
- Each domain gates after a programmable run of idle cycles.
- Each domain wakes on activity or on an explicit req/ack handshake.
- Sits in the NPU top level between the per-domain busy/request sources and the gating cells.

Parameters:
NUM_DOMAINS, 4, number of independently gated domains
IDLE_W, 8, width of the idle threshold and idle counters
WAKE_LAT, 2, cycles of enabled clock before a woken domain is reported ready; must be >= 1

Ports:
clk  in  1  system clock (ungated)
rst  in  1  synchronous reset, active-high
cfg_idle_thresh  in  IDLE_W  consecutive idle cycles before gating; 0 = gating disabled
force_on  in  1  global override; holds every domain enabled
domain_busy  in  NUM_DOMAINS  per-domain activity indication
wake_req  in  NUM_DOMAINS  per-domain wake request; level, held until ack
wake_ack  out  NUM_DOMAINS  domain running and ready for the requester
clk_en  out  NUM_DOMAINS  registered enable to the gating cell of each domain
domain_gated  out  NUM_DOMAINS  1 while the domain is in GATED

Behaviour:
- One independent FSM per domain; states ON, GATED, WAKE.
- Per domain there is an idle_cnt (IDLE_W bits) and a wake_cnt (clog2(WAKE_LAT+1) bits).
- A domain is "active" in a cycle if domain_busy[i] | wake_req[i] | force_on.

Reset (rst=1 at a clk edge):
- All domains go to ON; counters 0.
- Outputs: clk_en = all 1s (fail-safe running), domain_gated = 0, wake_ack = 0.
- Reset asserted mid-operation (GATED or WAKE) forces ON at the next edge; no WAKE_LAT delay.

ON state:
- clk_en=1.
- If active: idle_cnt <= 0.
- Else if cfg_idle_thresh != 0 and idle_cnt+1 >= cfg_idle_thresh: go to GATED, idle_cnt <= 0.
- Else: idle_cnt <= idle_cnt+1, saturating at all-ones.
- Result: cfg_idle_thresh = T gates after exactly T consecutive idle cycles.
- clk_en and domain_gated change on the edge entering GATED.

GATED state:
- clk_en=0, domain_gated=1.
- If active: go to WAKE, wake_cnt <= 0.
- On the edge entering WAKE: clk_en=1 and domain_gated=0.

WAKE state:
- clk_en=1.
- wake_cnt increments each cycle.
- When wake_cnt == WAKE_LAT-1: go to ON.
- Request sampled in GATED at edge t: WAKE from t+1, ON from t+1+WAKE_LAT.
- Active inputs in WAKE are ignored; the domain never regates from WAKE.

wake_ack[i]:
- Equals (state==ON) & wake_req[i]; combinational from the state register, zero-cycle when already ON.
- Requester holds wake_req until it sees ack.
- Deasserting wake_req before ack is legal; the wake still completes and the domain then idles out normally.

Threshold and override:
- cfg_idle_thresh is compared live. Lowering it below the current idle_cnt gates at the next idle edge.
- Setting it to 0 freezes gating; already-GATED domains stay GATED until active.
- force_on counts as active in every state, so it wakes GATED domains through WAKE (not instantly).

Independence: domains are fully independent; simultaneous events on different domains need no arbitration.

Optional Feature:
- Macro CLOCK_GATE_CTRL_STATS_EN.
- Defined: adds ports stat_clr (in, 1), stat_sel (in, clog2(NUM_DOMAINS)) and stat_gated_cycles (out, 32).
  - One 32-bit counter per domain increments every cycle the domain is GATED, saturating at 0xFFFFFFFF.
  - stat_clr zeroes all counters; clear wins over a same-cycle increment.
  - rst zeroes all counters.
  - stat_gated_cycles is the combinational mux of the counter selected by stat_sel.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, thresh=4, all inputs 0 → clk_en stays 1 for 4 idle cycles after rst release; clk_en[i]=0 and domain_gated[i]=1 from the 5th edge, all domains simultaneously.
2. Domain 1 GATED, wake_req[1]=1 held → clk_en[1]=1 one edge later; wake_ack[1]=1 exactly 1+WAKE_LAT (3) edges after the request; other domains unaffected.
3. thresh=4, busy[0] pulses every 3 cycles → domain 0 never gates; thresh then set to 0 with idle input → never gates.
4. Domains 0–3 GATED, force_on=1 → all pass through WAKE and reach ON together after 3 edges; hold force_on 20 cycles → no gating.
5. Domain 2 in WAKE (wake_cnt=0), rst=1 one cycle → next cycle ON, clk_en=1, wake_ack follows wake_req immediately.
6. With CLOCK_GATE_CTRL_STATS_EN: gate domain 3 for 10 cycles → stat_sel=3 reads 10; stat_clr in the same cycle as a GATED cycle → reads 0.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_gate_ctrl
// Description : Per-domain idle-timeout clock-gate enable controller with
//               req/ack wake handshake. Optional gated-cycle statistics are
//               enabled with the macro CLOCK_GATE_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_gate_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_W      = 8,
    parameter int WAKE_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDLE_W-1:0]      cfg_idle_thresh,
    input  logic                   force_on,
    input  logic [NUM_DOMAINS-1:0] domain_busy,
    input  logic [NUM_DOMAINS-1:0] wake_req,
    output logic [NUM_DOMAINS-1:0] wake_ack,
    output logic [NUM_DOMAINS-1:0] clk_en,
    output logic [NUM_DOMAINS-1:0] domain_gated
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    input  logic                   stat_clr,
    input  logic [(NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1)-1:0] stat_sel,
    output logic [31:0]            stat_gated_cycles
`endif
);

    localparam int WAKE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT + 1) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W:0]   EXT_ONE   = (IDLE_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_ON    = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

`ifdef CLOCK_GATE_CTRL_STATS_EN
    localparam int SEL_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    logic [NUM_DOMAINS-1:0][31:0] gated_cnt_bus;
`endif

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_domain
        state_t              state, state_nxt;
        logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
        logic [WAKE_W-1:0]   wake_cnt, wake_cnt_nxt;
        logic [IDLE_W:0]     idle_inc_ext;
        logic                en_q;
        logic                active;

        assign active       = domain_busy[i] | wake_req[i] | force_on;
        // Widened compare so an all-ones idle_cnt cannot wrap past the threshold.
        assign idle_inc_ext = {1'b0, idle_cnt} + EXT_ONE;

        always_comb begin
            state_nxt    = state;
            idle_cnt_nxt = idle_cnt;
            wake_cnt_nxt = wake_cnt;
            unique case (state)
                ST_ON: begin
                    if (active) begin
                        idle_cnt_nxt = '0;
                    end else if ((cfg_idle_thresh != '0) &&
                                 (idle_inc_ext >= {1'b0, cfg_idle_thresh})) begin
                        state_nxt    = ST_GATED;
                        idle_cnt_nxt = '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt_nxt = idle_cnt + IDLE_ONE;
                    end
                end
                ST_GATED: begin
                    if (active) begin
                        state_nxt    = ST_WAKE;
                        wake_cnt_nxt = '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state_nxt = ST_ON;
                    end else begin
                        wake_cnt_nxt = wake_cnt + WAKE_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_ON;
                end
            endcase
        end

        // Enable is a dedicated flop so the gating cell sees a glitch-free level.
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= ST_ON;
                idle_cnt <= '0;
                wake_cnt <= '0;
                en_q     <= 1'b1;
            end else begin
                state    <= state_nxt;
                idle_cnt <= idle_cnt_nxt;
                wake_cnt <= wake_cnt_nxt;
                en_q     <= (state_nxt != ST_GATED);
            end
        end

        assign clk_en[i]       = en_q;
        assign domain_gated[i] = (state == ST_GATED);
        assign wake_ack[i]     = (state == ST_ON) & wake_req[i];

`ifdef CLOCK_GATE_CTRL_STATS_EN
        logic [31:0] gated_cnt;

        always_ff @(posedge clk) begin
            if (rst || stat_clr) begin
                gated_cnt <= '0;
            end else if ((state == ST_GATED) && (gated_cnt != '1)) begin
                gated_cnt <= gated_cnt + 32'd1;
            end
        end

        assign gated_cnt_bus[i] = gated_cnt;
`endif
    end : g_domain

`ifdef CLOCK_GATE_CTRL_STATS_EN
    always_comb begin
        stat_gated_cycles = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (stat_sel == SEL_W'(d)) begin
                stat_gated_cycles = gated_cnt_bus[d];
            end
        end
    end
`endif

endmodule : clock_gate_ctrl
`default_nettype wire
